dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the core's load/store unit and `mem_ram`. It initiates the 256-bit line read and the byte/half/word write on `mem_ram`'s interface, holds 8 lines of 32 bytes, and returns one 32-bit word per load. The LSU sees a simple request/ready handshake. The memory sees exactly the port set `mem_ram` exposes.

## Interface
Parameters:
- `LINES`, default 8: number of cache lines; power of two; index = `addr[4+log2(LINES):5]`.
- `TAG_W`, default 24: tag width = 32 − 5 − log2(LINES).

Ports, clock and reset first:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_req` in 1: access request; sampled only in IDLE.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_sel` in `SmallMemNumlog2`: `byte_sel` / `half_word_sel` / `word_sel`.
- `cpu_rdata` out 32: load word, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse, for loads and stores.
- `cpu_busy` out 1: 1 whenever state ≠ IDLE.
- `mem_ce` out 1: line read enable.
- `mem_rd_addr` out 32: line-aligned read address (`addr[4:0]`=0).
- `mem_rd_data` in 256: line; word k at bits [32k+31:32k]; combinational from `mem_ce`/`mem_rd_addr`.
- `mem_we` out 1: write enable.
- `mem_wr_addr` out 32, `mem_wr_data` out 32, `mem_wr_sel` out `SmallMemNumlog2`: store forwarded unchanged.

## Operation
- Arrays: `valid[LINES]`, `tag[LINES]`, `data[LINES]` (256 bits each). Registered, no RAM macro.
- Request latch: in IDLE with `cpu_req`=1, capture `we`, `addr`, `wdata`, `sel` into a request register. The lookup uses the captured copy.
- States:
  - IDLE: on `cpu_req`, load hit → RESP; load miss → REFILL; store → WRITE.
  - REFILL: drive `mem_ce`=1 and `mem_rd_addr`={addr[31:5],5'b0}. At the edge, write `mem_rd_data` into `data[idx]`, set `tag[idx]` and `valid[idx]`=1, then → RESP.
  - WRITE: drive `mem_we`=1 with the latched addr/data/sel. If the line is a hit, merge into `data[idx]` word `addr[4:2]`:
    - `byte_sel` writes lane 0.
    - `half_word_sel` writes lanes 0-1.
    - `word_sel` writes lanes 0-3.
    - This is identical to memory lane semantics and is independent of `addr[1:0]`.
    - On a miss the cache is unchanged. Then → RESP.
  - RESP: `cpu_ready`=1. For loads, `cpu_rdata`=`data[idx]` word `addr[4:2]`. For stores, `cpu_rdata`=0. Then → IDLE.
  - An invalid `cpu_sel` on a store still produces a WRITE cycle with that sel. The memory ignores it, and the cache is unchanged.
- Hit = `valid[idx]` && `tag[idx]`==addr tag.
- Byte/half extraction and sign extension are done by the LSU, not here.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, all `valid`=0, request register=0, `cpu_ready`=`cpu_busy`=`mem_ce`=`mem_we`=0, `cpu_rdata`=0, all `mem_*` address/data/sel outputs=0.
- Reset mid-REFILL: the line is not validated and no `cpu_ready` is produced. Reset mid-WRITE: `mem_we` drops the same edge; the memory write on that edge is not guaranteed.
- Load hit: request in cycle N, `cpu_ready` in N+1. Load miss: `mem_ce` in N+1, `cpu_ready` in N+2. Store (hit or miss): `mem_we` in N+1, `cpu_ready` in N+2.
- `mem_ce` and `mem_we` are never asserted together and each lasts exactly one cycle.
- `cpu_req` outside IDLE is ignored; the LSU must hold or reissue. Back-to-back maximum rate is one hit load every 2 cycles.
- A load following a store to the same line returns merged data (write-through keeps cache and memory coherent).
- Index conflict: a refill overwrites the resident line unconditionally (no dirty state).

## Configuration
- `DCACHE_STATS_EN` defined adds outputs `hit_cnt` out 32 and `miss_cnt` out 32.
  - They count load hits and load misses in IDLE, reset to 0, and wrap at 2^32.
  - Stores are not counted.
- `DCACHE_STATS_EN` not defined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then load `0x0000_0044`, memory line at 0x40 word1=`0xDEADBEEF` → `mem_ce` pulse with `mem_rd_addr`=0x40 in N+1; `cpu_ready` with `cpu_rdata`=`0xDEADBEEF` in N+2; `miss_cnt`=1.
- Repeat load `0x0000_0048` (word2=`0x12345678`) → no `mem_ce`; `cpu_ready` in N+1 with `0x12345678`; `hit_cnt`=1.
- Store word `0xA5A5A5A5` to 0x44 (hit) → `mem_we`=1, `mem_wr_sel`=`word_sel`, `mem_wr_addr`=0x44; then load 0x44 hits and returns `0xA5A5A5A5`.
- Store byte `0x000000FF` to 0x46 on a hit line holding `0x11223344` → cached word becomes `0x112233FF`; later miss-free load returns it.
- Load 0x140 (same index as 0x40, different tag) → miss and refill; then load 0x44 misses again; `miss_cnt`=3.
- Assert `rst`=0 during REFILL → `valid` cleared, no `cpu_ready`; next load of the same address misses.

Source files
------------

// File: rtl/dcache_if.sv
// -----------------------------------------------------------------------------
// dcache_if: bundle of the LSU-side and memory-side signals of dcache_ctrl.
//
// LSU side (cpu_*):
//   cpu_req   : access request, sampled only while the cache is idle
//   cpu_we    : 1 = store, 0 = load
//   cpu_addr  : byte address
//   cpu_wdata : store data
//   cpu_sel   : byte_sel / half_word_sel / word_sel
//   cpu_rdata : load word, valid while cpu_ready = 1 (0 for stores)
//   cpu_ready : one-cycle completion pulse
//   cpu_busy  : 1 whenever the controller is not idle
//
// Memory side (mem_*), matching the mem_ram port set:
//   mem_ce / mem_rd_addr / mem_rd_data : 256-bit line read, data combinational
//   mem_we / mem_wr_addr / mem_wr_data / mem_wr_sel : forwarded store
//
// Handshake: a request is accepted on a rising edge where cpu_req = 1 and
// cpu_busy = 0; the LSU holds or reissues requests raised while busy. The
// access completes with exactly one cpu_ready cycle and no back-pressure.
// mem_ce and mem_we are single-cycle strobes, never asserted together.
//
// Modports: slave = the cache controller, master = the LSU/memory environment.
// -----------------------------------------------------------------------------
interface dcache_if #(
    parameter int SEL_W = 2
);
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [SEL_W-1:0] cpu_sel;
    logic [31:0]      cpu_rdata;
    logic             cpu_ready;
    logic             cpu_busy;

    logic             mem_ce;
    logic [31:0]      mem_rd_addr;
    logic [255:0]     mem_rd_data;
    logic             mem_we;
    logic [31:0]      mem_wr_addr;
    logic [31:0]      mem_wr_data;
    logic [SEL_W-1:0] mem_wr_sel;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, mem_rd_data,
        output cpu_rdata, cpu_ready, cpu_busy,
        output mem_ce, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, mem_wr_sel
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel, mem_rd_data,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  mem_ce, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, mem_wr_sel
    );
endinterface

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller. LINES lines of 32 bytes, one 32-bit word returned per load.
//
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-low reset
//   bus         : dcache_if.slave (LSU request/ready + mem_ram read/write)
//   dbg_state_o : current FSM state (0 IDLE, 1 REFILL, 2 WRITE, 3 RESP)
//   hit_cnt     : load hits accepted in IDLE    (only with DCACHE_STATS_EN)
//   miss_cnt    : load misses accepted in IDLE  (only with DCACHE_STATS_EN)
//
// Optional feature macro: DCACHE_STATS_EN adds the two wrapping counters.
//
// Select encoding (shared with mem_ram): 0 byte, 1 half word, 2 word,
// 3 invalid. Lanes are always taken from the low end of the word, so the
// merge ignores addr[1:0], exactly as the memory does.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINES = 8,
    parameter int TAG_W = 32 - 5 - $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst,
    dcache_if.slave     bus,
    output logic [1:0]  dbg_state_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);

    localparam logic [1:0] BYTE_SEL = 2'd0;
    localparam logic [1:0] HALF_SEL = 2'd1;
    localparam logic [1:0] WORD_SEL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Request register
    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [1:0]  req_sel_q;

    // Cache arrays
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [255:0]     data_q [LINES];

    // Lookup of the incoming request. The FSM has to decide hit/miss in the
    // same IDLE cycle the request is latched, so it looks at the live bus,
    // which carries exactly the value being captured.
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             cpu_hit;

    assign cpu_idx = bus.cpu_addr[5 +: IDX_W];
    assign cpu_tag = bus.cpu_addr[31 -: TAG_W];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Lookup of the latched request, used by REFILL/WRITE/RESP.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       req_word;
    logic             req_hit;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;

    assign req_idx  = req_addr_q[5 +: IDX_W];
    assign req_tag  = req_addr_q[31 -: TAG_W];
    assign req_word = req_addr_q[4:2];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cur_word = data_q[req_idx][{req_word, 5'b00000} +: 32];

    always_comb begin
        merged_word = cur_word;
        case (req_sel_q)
            BYTE_SEL: merged_word = {cur_word[31:8],  req_wdata_q[7:0]};
            HALF_SEL: merged_word = {cur_word[31:16], req_wdata_q[15:0]};
            WORD_SEL: merged_word = req_wdata_q;
            default:  merged_word = cur_word;  // invalid sel leaves the line alone
        endcase
    end

    // FSM next-state and outputs. All memory-side address/data outputs are
    // forced to zero outside their own state so idle/reset values are clean.
    always_comb begin
        state_d         = state_q;
        bus.cpu_rdata   = 32'd0;
        bus.cpu_ready   = 1'b0;
        bus.mem_ce      = 1'b0;
        bus.mem_rd_addr = 32'd0;
        bus.mem_we      = 1'b0;
        bus.mem_wr_addr = 32'd0;
        bus.mem_wr_data = 32'd0;
        bus.mem_wr_sel  = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we)   state_d = S_WRITE;
                    else if (cpu_hit) state_d = S_RESP;
                    else              state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                bus.mem_ce      = 1'b1;
                bus.mem_rd_addr = {req_addr_q[31:5], 5'b00000};
                state_d         = S_RESP;
            end
            S_WRITE: begin
                bus.mem_we      = 1'b1;
                bus.mem_wr_addr = req_addr_q;
                bus.mem_wr_data = req_wdata_q;
                bus.mem_wr_sel  = req_sel_q;
                state_d         = S_RESP;
            end
            S_RESP: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_rdata = req_we_q ? 32'd0 : cur_word;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_busy = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;

    // State and request register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.cpu_req) begin
                req_we_q    <= bus.cpu_we;
                req_addr_q  <= bus.cpu_addr;
                req_wdata_q <= bus.cpu_wdata;
                req_sel_q   <= bus.cpu_sel;
            end
        end
    end

    // Valid bits are the only array state that needs reset; a reset during
    // REFILL wins, so the line being filled is never validated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (state_q == S_REFILL) begin
            valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == S_REFILL) begin
                data_q[req_idx] <= bus.mem_rd_data;
                tag_q[req_idx]  <= req_tag;
            end else if (state_q == S_WRITE && req_hit) begin
                data_q[req_idx][{req_word, 5'b00000} +: 32] <= merged_word;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Load hit/miss counters, counted when the load is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (state_q == S_IDLE && bus.cpu_req && !bus.cpu_we) begin
            if (cpu_hit) hit_cnt  <= hit_cnt + 32'd1;
            else         miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
